// File: rtl/cpu_consts.sv
// Constants shared by the core's memory stage and the data-memory responder.
// Holds the access-size encoding, the responder's FSM states and a saturating-counter helper.
package cpu_consts;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic {
        DMEM_INIT,
        DMEM_READY
    } dmem_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Merges right-aligned store data into a 64-bit row at the addressed byte lane; flags misalignment.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module dmem_lane_merge
    import cpu_consts::*;
(
    input  logic [1:0]  size,
    input  logic [2:0]  lane,
    input  logic [63:0] wr_data,
    input  logic [63:0] old_row,
    output logic [63:0] merged_row,
    output logic        misaligned
);

    logic [7:0]  base_mask;
    logic [7:0]  byte_mask;
    logic [63:0] shifted;

    always_comb begin
        base_mask  = 8'h01;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE:  begin base_mask = 8'h01; misaligned = 1'b0;          end
            SZ_HALF:  begin base_mask = 8'h03; misaligned = lane[0];       end
            SZ_WORD:  begin base_mask = 8'h0F; misaligned = |lane[1:0];    end
            default:  begin base_mask = 8'hFF; misaligned = |lane;         end
        endcase
        // A misaligned mask may shift lanes off the top; the write is blocked in that case anyway.
        byte_mask = base_mask << lane;
        shifted   = wr_data << {lane, 3'b000};
        for (int i = 0; i < 8; i++) begin
            merged_row[8*i +: 8] = byte_mask[i] ? shifted[8*i +: 8] : old_row[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-filled 64-bit row array, one load or byte-merged store per cycle.
// Latency: loads combinational, stores commit at the next edge; DMEM_PERF_CNT_EN adds access counters.
// Backpressure: none; the core is held in reset until init_done_o, errors are flagged via mem_err_o.
module dmem_responder
    import cpu_consts::*;
#(
    parameter int          DEPTH_ROWS = 512,
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_mem_req_i,
    input  logic [63:0] data_mem_addr_i,
    input  logic [1:0]  data_mem_byte_en_i,
    input  logic        data_mem_wr_i,
    input  logic [63:0] data_mem_wr_data_i,
    output logic [63:0] data_mem_rd_data_o,
    output logic        mem_err_o,
    output logic [63:0] err_addr_o,
    output logic        init_done_o
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] ld_cnt_o,
    output logic [31:0] st_cnt_o,
    output logic [31:0] err_cnt_o
`endif
);

    localparam int          AW   = $clog2(DEPTH_ROWS);
    localparam logic [63:0] SPAN = 64'(DEPTH_ROWS) * 64'd8;

    logic [63:0]   mem [DEPTH_ROWS];
    dmem_state_e   state;
    logic [AW-1:0] cnt;

    logic [63:0]   off;
    logic [AW-1:0] row_idx;
    logic          in_range;
    logic          misaligned;
    logic [63:0]   row_dat;
    logic [63:0]   merged_dat;
    logic          ld_ok;
    logic          st_ok;

    assign off      = data_mem_addr_i - BASE_ADDR;
    assign row_idx  = off[AW+2:3];
    assign in_range = (data_mem_addr_i >= BASE_ADDR) && (off < SPAN);
    assign row_dat  = mem[row_idx];

    dmem_lane_merge u_lane_merge (
        .size       (data_mem_byte_en_i),
        .lane       (data_mem_addr_i[2:0]),
        .wr_data    (data_mem_wr_data_i),
        .old_row    (row_dat),
        .merged_row (merged_dat),
        .misaligned (misaligned)
    );

    assign mem_err_o = data_mem_req_i & (~in_range | misaligned | ~init_done_o);
    assign ld_ok     = data_mem_req_i & ~data_mem_wr_i & ~mem_err_o;
    assign st_ok     = data_mem_req_i &  data_mem_wr_i & ~mem_err_o;

    assign data_mem_rd_data_o = ld_ok ? row_dat : 64'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= DMEM_INIT;
            cnt         <= '0;
            init_done_o <= 1'b0;
        end else begin
            case (state)
                DMEM_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state       <= DMEM_READY;
                        init_done_o <= 1'b1;
                    end
                end
                default: init_done_o <= 1'b1;
            endcase
        end
    end

    // Array has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == DMEM_INIT) begin
                mem[cnt] <= 64'd0;
            end else if (st_ok) begin
                mem[row_idx] <= merged_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_addr_o <= 64'd0;
        end else if (mem_err_o) begin
            err_addr_o <= data_mem_addr_i;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    // mem_err_o already covers requests during INIT, so only ld/st need the ready gating.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt_o  <= 32'd0;
            st_cnt_o  <= 32'd0;
            err_cnt_o <= 32'd0;
        end else begin
            if (ld_ok && init_done_o) ld_cnt_o  <= sat_inc(ld_cnt_o);
            if (st_ok && init_done_o) st_cnt_o  <= sat_inc(st_cnt_o);
            if (mem_err_o)            err_cnt_o <= sat_inc(err_cnt_o);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: zero-fill timing, byte-lane stores, alignment and range errors.
// Define DMEM_PERF_CNT_EN to also check the access counters.
module tb_dmem_responder;
    import cpu_consts::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [63:0] addr;
    logic [1:0]  sz;
    logic        wr;
    logic [63:0] wdat;
    logic [63:0] rd_data;
    logic        mem_err;
    logic [63:0] err_addr;
    logic        init_done;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] ld_cnt;
    logic [31:0] st_cnt;
    logic [31:0] err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] got_rd;
    logic        got_err;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk                (clk),
        .reset              (reset),
        .data_mem_req_i     (req),
        .data_mem_addr_i    (addr),
        .data_mem_byte_en_i (sz),
        .data_mem_wr_i      (wr),
        .data_mem_wr_data_i (wdat),
        .data_mem_rd_data_o (rd_data),
        .mem_err_o          (mem_err),
        .err_addr_o         (err_addr),
        .init_done_o        (init_done)
`ifdef DMEM_PERF_CNT_EN
        ,
        .ld_cnt_o           (ld_cnt),
        .st_cnt_o           (st_cnt),
        .err_cnt_o          (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request for a cycle; combinational outputs are sampled mid-cycle.
    task automatic access(input logic w, input logic [1:0] s, input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        req  = 1'b1;
        wr   = w;
        sz   = s;
        addr = a;
        wdat = d;
        #2;
        got_rd  = rd_data;
        got_err = mem_err;
        @(posedge clk);
        #1;
        req  = 1'b0;
        wr   = 1'b0;
    endtask

    task automatic load(input logic [1:0] s, input logic [63:0] a);
        access(1'b0, s, a, 64'd0);
    endtask

    task automatic store(input logic [1:0] s, input logic [63:0] a, input logic [63:0] d);
        access(1'b1, s, a, d);
    endtask

    // Reset released at a negedge; init_done must appear after exactly 512 edges.
    task automatic release_and_wait_init(input string tag);
        @(negedge clk);
        reset = 1'b0;
        repeat (511) @(posedge clk);
        #1;
        check({tag, "_done_at_511"}, {63'd0, init_done}, 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_at_512"}, {63'd0, init_done}, 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        wr    = 1'b0;
        sz    = SZ_BYTE;
        addr  = 64'd0;
        wdat  = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_init_done", {63'd0, init_done}, 64'd0);
        check("rst_err_addr",  err_addr, 64'd0);
        check("rst_mem_err",   {63'd0, mem_err}, 64'd0);
        check("rst_rd_data",   rd_data, 64'd0);

        // Request during INIT, then restart the fill around cycle 100.
        reset = 1'b0;
        repeat (9) @(posedge clk);
        load(SZ_DWORD, 64'h8000_0000);
        check("init_req_err",   {63'd0, got_err}, 64'd1);
        check("init_req_rd",    got_rd, 64'd0);
        check("init_req_eaddr", err_addr, 64'h8000_0000);
        repeat (89) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_done",  {63'd0, init_done}, 64'd0);
        check("midrst_eaddr", err_addr, 64'd0);
        release_and_wait_init("fill");

        // Last row zero-filled.
        load(SZ_DWORD, 64'h8000_0FF8);
        check("last_row_err", {63'd0, got_err}, 64'd0);
        check("last_row_rd",  got_rd, 64'd0);

        // Dword then byte merge into row 2.
        store(SZ_DWORD, 64'h8000_0010, 64'h1122_3344_5566_7788);
        check("st_dw_err", {63'd0, got_err}, 64'd0);
        store(SZ_BYTE, 64'h8000_0013, 64'h0000_0000_0000_00AB);
        load(SZ_DWORD, 64'h8000_0010);
        check("merge_rd", got_rd, 64'h1122_3344_AB66_7788);

        // Word in upper lane, then misaligned half must leave row 4 alone.
        store(SZ_WORD, 64'h8000_0024, 64'h0000_0000_DEAD_BEEF);
        load(SZ_WORD, 64'h8000_0024);
        check("word_hi_rd", got_rd, 64'hDEAD_BEEF_0000_0000);
        store(SZ_HALF, 64'h8000_0021, 64'h0000_0000_0000_BEEF);
        check("misal_err",   {63'd0, got_err}, 64'd1);
        check("misal_eaddr", err_addr, 64'h8000_0021);
        load(SZ_DWORD, 64'h8000_0020);
        check("misal_row4", got_rd, 64'hDEAD_BEEF_0000_0000);
        check("misal_ok_err", {63'd0, got_err}, 64'd0);

        // Out of range on both sides.
        load(SZ_DWORD, 64'h7FFF_FFF8);
        check("below_err", {63'd0, got_err}, 64'd1);
        check("below_rd",  got_rd, 64'd0);
        load(SZ_DWORD, 64'h8000_1000);
        check("above_err",   {63'd0, got_err}, 64'd1);
        check("above_rd",    got_rd, 64'd0);
        check("above_eaddr", err_addr, 64'h8000_1000);
        store(SZ_DWORD, 64'h8000_1000, 64'h5555_5555_5555_5555);
        check("above_st_err", {63'd0, got_err}, 64'd1);
        load(SZ_DWORD, 64'h8000_0000);
        check("no_alias_row0", got_rd, 64'd0);

        // Half at lane 6, and an idle cycle.
        store(SZ_HALF, 64'h8000_0006, 64'h0000_0000_0000_CAFE);
        load(SZ_DWORD, 64'h8000_0000);
        check("half_hi_rd", got_rd, 64'hCAFE_0000_0000_0000);
        @(negedge clk);
        addr = 64'h8000_0000;
        #2;
        check("idle_rd",  rd_data, 64'd0);
        check("idle_err", {63'd0, mem_err}, 64'd0);

`ifdef DMEM_PERF_CNT_EN
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("cnt_rst_ld", {32'd0, ld_cnt}, 64'd0);
        release_and_wait_init("perf");
        load(SZ_DWORD, 64'h8000_0000);
        load(SZ_DWORD, 64'h8000_0008);
        store(SZ_WORD, 64'h8000_0010, 64'h1234_5678);
        load(SZ_WORD, 64'h8000_0014);
        store(SZ_BYTE, 64'h8000_0003, 64'h99);
        load(SZ_WORD, 64'h8000_0002);
        check("cnt_ld",  {32'd0, ld_cnt},  64'd3);
        check("cnt_st",  {32'd0, st_cnt},  64'd2);
        check("cnt_err", {32'd0, err_cnt}, 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's data memory interface (req/addr/byte_en/wr/wr_data -> rd_data).
- Holds a row-organised 64-bit memory.
- Services one access per cycle: reads are combinational, so the single-cycle core is never stalled; writes merge byte lanes and commit at the clock edge.
- After reset, a zero-fill state machine clears the array. The SoC top holds the core in reset until init_done_o is high.

Parameters:
- DEPTH_ROWS, 512, number of 64-bit rows; must be a power of two and at least 2.
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of row 0; must be 8-byte aligned.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- data_mem_req_i  in  1  access request valid this cycle
- data_mem_addr_i  in  64  full byte address
- data_mem_byte_en_i  in  2  access size: 00 byte, 01 half, 10 word, 11 dword
- data_mem_wr_i  in  1  1 = store, 0 = load
- data_mem_wr_data_i  in  64  store data, right-aligned (value in the low bits)
- data_mem_rd_data_o  out  64  full addressed row; the core extracts the lane using addr[2:0]
- mem_err_o  out  1  current access is misaligned or out of range (combinational)
- err_addr_o  out  64  address of the most recent erroring access (registered)
- init_done_o  out  1  zero-fill complete; memory usable

Behaviour:
- Reset (synchronous, active-high): FSM goes to INIT, row counter = 0, err_addr_o = 0, init_done_o = 0. Array contents are not reset directly.
- FSM INIT:
  - Each cycle, writes 0 to row[cnt] and increments cnt.
  - When cnt == DEPTH_ROWS-1, the final row is written and the FSM moves to READY next cycle.
  - INIT lasts exactly DEPTH_ROWS cycles after reset deasserts.
- FSM READY: init_done_o = 1. Stays in READY until reset.
- Reset asserted mid-INIT restarts the fill from row 0.
- Access decode:
  - off = addr - BASE_ADDR
  - row = off[log2(DEPTH_ROWS)+2:3]
  - lane = addr[2:0]
  - in_range = addr >= BASE_ADDR and off < DEPTH_ROWS*8
- Alignment rules:
  - half: lane[0] == 0
  - word: lane[1:0] == 0
  - dword: lane == 0
- mem_err_o = req & (~in_range | misaligned | ~init_done_o).
- err_addr_o loads data_mem_addr_i on any clock edge where mem_err_o = 1.
- Load: data_mem_rd_data_o = row[row] in the same cycle.
- Output is 0 when req = 0, on a store, or when mem_err_o = 1.
- Store:
  - Byte mask = (1, 3, F, FF by size) << lane.
  - Data = wr_data << (8*lane).
  - Only masked bytes of row[row] update, at the clock edge.
  - No write occurs when mem_err_o = 1.
- Read-during-write ordering: a load in the cycle after a store to the same row sees the new data. Because one port carries one access per cycle, a simultaneous load and store cannot occur.
- Errors never alter array state. A misaligned access is not split.
- Zero-size requests and req = 0 cycles: no state change except the INIT FSM.

Optional Feature:
- DMEM_PERF_CNT_EN defined:
  - Adds outputs ld_cnt_o[31:0], st_cnt_o[31:0] and err_cnt_o[31:0].
  - Each counts successful loads, successful stores and erroring accesses respectively.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
  - Counting is suppressed while init_done_o = 0, except err_cnt_o, which counts requests made during INIT.
- DMEM_PERF_CNT_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_consts: add the size-encoding constants SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD (2'b00..2'b11) and the dmem_state_e enum {DMEM_INIT, DMEM_READY}; the core's memory stage uses the same size constants.
- One sub-module, dmem_lane_merge (combinational): size + lane + wr_data + old row -> merged row + misaligned flag.
- The FSM, array and counters stay in the top.

Test Plan:
- Reset, then run 512 cycles with DEPTH_ROWS = 512 -> init_done_o rises on cycle 512 exactly; a load at 0x8000_0FF8 returns 0.
- Store dword 0x1122334455667788 @0x8000_0010, then a byte store of 0xAB @0x8000_0013 -> load @0x8000_0010 returns 0x11223344AB667788.
- Half store of 0xBEEF @0x8000_0021 (misaligned) -> mem_err_o = 1, err_addr_o = 0x8000_0021 next cycle, row 4 unchanged.
- Load @0x7FFF_FFF8 and load @BASE_ADDR + 512*8 -> mem_err_o = 1, rd_data = 0, no write.
- Request during INIT, then pulse reset mid-INIT at cycle 100 -> mem_err_o = 1; init_done_o rises 512 cycles after reset deasserts.
- With DMEM_PERF_CNT_EN defined: 3 loads, 2 stores and 1 misaligned access -> ld_cnt_o = 3, st_cnt_o = 2, err_cnt_o = 1.
